// File: rtl/usb_rx_packet_decoder.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx_packet_decoder
// Purpose  : Decodes the UTMI receive stream into token, SOF, handshake and
//            CRC-stripped data payload events, with PID, CRC and length checks.
// Revision : 1.0 - initial release
// ============================================================================
module usb_rx_packet_decoder #(
   parameter int MAX_PAYLOAD = 1024
) (
   input  logic        ulpi_clk60_i,
   input  logic        ulpi_rst_i,
   input  logic [7:0]  utmi_data_in_i,
   input  logic        utmi_rxvalid_i,
   input  logic        utmi_rxactive_i,
   input  logic        utmi_rxerror_i,
   output logic        token_valid_o,
   output logic [3:0]  token_pid_o,
   output logic [6:0]  token_addr_o,
   output logic [3:0]  token_ep_o,
   output logic        sof_valid_o,
   output logic [10:0] frame_num_o,
   output logic        hshake_valid_o,
   output logic [3:0]  hshake_pid_o,
   output logic        data_start_o,
   output logic [3:0]  data_pid_o,
   output logic        data_valid_o,
   output logic [7:0]  data_o,
   output logic        data_end_o,
   output logic        data_crc_ok_o,
   output logic        rx_error_o
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_TOKEN   = 3'd1,
      ST_DATA    = 3'd2,
      ST_HSHAKE  = 3'd3,
      ST_DISCARD = 3'd4
   } state_t;

   localparam logic [11:0] C_MAX_LEN = 12'(MAX_PAYLOAD + 2);

   state_t       r_state;
   logic         r_active_q;
   logic         r_skip;
   logic         r_err;
   logic [3:0]   r_pid;
   logic [10:0]  r_cnt;
   logic [4:0]   r_crc5;
   logic [15:0]  r_crc16;
   logic [10:0]  r_field;
   logic [7:0]   r_hold0;
   logic [7:0]   r_hold1;
   logic [1:0]   r_hold_cnt;

   logic         w_accept;
   logic         w_eop;
   logic         w_pid_ok;
   logic [10:0]  w_cnt_next;
   logic [4:0]   w_crc5_next;
   logic [15:0]  w_crc16_next;
   logic         w_emit;
   logic         w_tok_good;
   logic         w_hs_good;
   logic         w_data_good;

   // Bit-serial CRC steps unrolled over one byte, LSB first.
   function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] din);
      logic [4:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (din[i] ^ c[4]) c = {c[3:0], 1'b0} ^ 5'h05;
         else               c = {c[3:0], 1'b0};
      end
      return c;
   endfunction

   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] din);
      logic [15:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (din[i] ^ c[15]) c = {c[14:0], 1'b0} ^ 16'h8005;
         else                c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

   assign w_accept     = utmi_rxactive_i & utmi_rxvalid_i;
   assign w_eop        = r_active_q & ~utmi_rxactive_i;
   assign w_pid_ok     = (utmi_data_in_i[7:4] == ~utmi_data_in_i[3:0]);
   assign w_cnt_next   = (r_cnt == 11'h7FF) ? r_cnt : r_cnt + 11'd1;
   assign w_crc5_next  = crc5_byte(r_crc5, utmi_data_in_i);
   assign w_crc16_next = crc16_byte(r_crc16, utmi_data_in_i);
   assign w_emit       = ({1'b0, w_cnt_next} <= C_MAX_LEN);
   assign w_tok_good   = (r_cnt == 11'd2) && (r_crc5 == 5'h0C) && !r_err;
   assign w_hs_good    = (r_cnt == 11'd0) && !r_err;
   assign w_data_good  = (r_cnt >= 11'd2) && ({1'b0, r_cnt} <= C_MAX_LEN) &&
                         (r_crc16 == 16'h800D) && !r_err;

   always_ff @(posedge ulpi_clk60_i or posedge ulpi_rst_i) begin
      if (ulpi_rst_i) begin
         r_state        <= ST_IDLE;
         r_active_q     <= 1'b0;
         r_skip         <= 1'b1;
         r_err          <= 1'b0;
         r_pid          <= 4'd0;
         r_cnt          <= 11'd0;
         r_crc5         <= 5'h1F;
         r_crc16        <= 16'hFFFF;
         r_field        <= 11'd0;
         r_hold0        <= 8'd0;
         r_hold1        <= 8'd0;
         r_hold_cnt     <= 2'd0;
         token_valid_o  <= 1'b0;
         token_pid_o    <= 4'd0;
         token_addr_o   <= 7'd0;
         token_ep_o     <= 4'd0;
         sof_valid_o    <= 1'b0;
         frame_num_o    <= 11'd0;
         hshake_valid_o <= 1'b0;
         hshake_pid_o   <= 4'd0;
         data_start_o   <= 1'b0;
         data_pid_o     <= 4'd0;
         data_valid_o   <= 1'b0;
         data_o         <= 8'd0;
         data_end_o     <= 1'b0;
         data_crc_ok_o  <= 1'b0;
         rx_error_o     <= 1'b0;
      end else begin
         token_valid_o  <= 1'b0;
         sof_valid_o    <= 1'b0;
         hshake_valid_o <= 1'b0;
         data_start_o   <= 1'b0;
         data_valid_o   <= 1'b0;
         data_end_o     <= 1'b0;
         rx_error_o     <= 1'b0;
         r_active_q     <= utmi_rxactive_i;
         // A reset inside a packet leaves the rest of that packet unparsed.
         if (!utmi_rxactive_i) r_skip <= 1'b0;

         if (w_eop) begin
            case (r_state)
               ST_TOKEN: begin
                  if (w_tok_good) begin
                     if (r_pid == 4'h5) begin
                        sof_valid_o <= 1'b1;
                        frame_num_o <= r_field;
                     end else begin
                        token_valid_o <= 1'b1;
                        token_pid_o   <= r_pid;
                        token_addr_o  <= r_field[6:0];
                        token_ep_o    <= r_field[10:7];
                     end
                  end else begin
                     rx_error_o <= 1'b1;
                  end
               end
               ST_DATA: begin
                  data_end_o    <= 1'b1;
                  data_crc_ok_o <= w_data_good;
                  rx_error_o    <= !w_data_good;
               end
               ST_HSHAKE: begin
                  if (w_hs_good) begin
                     hshake_valid_o <= 1'b1;
                     hshake_pid_o   <= r_pid;
                  end else begin
                     rx_error_o <= 1'b1;
                  end
               end
               ST_DISCARD: rx_error_o <= r_err;
               default: ;
            endcase
            r_state    <= ST_IDLE;
            r_err      <= 1'b0;
            r_hold_cnt <= 2'd0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_err <= utmi_rxactive_i &
                           (r_err | utmi_rxerror_i | (w_accept & !r_skip & !w_pid_ok));
                  if (w_accept && !r_skip) begin
                     r_pid      <= utmi_data_in_i[3:0];
                     r_cnt      <= 11'd0;
                     r_crc5     <= 5'h1F;
                     r_crc16    <= 16'hFFFF;
                     r_hold_cnt <= 2'd0;
                     if (!w_pid_ok) begin
                        r_state <= ST_DISCARD;
                     end else if (utmi_data_in_i[1:0] == 2'b01 || utmi_data_in_i[3:0] == 4'h4) begin
                        r_state <= ST_TOKEN;
                     end else if (utmi_data_in_i[1:0] == 2'b11) begin
                        r_state      <= ST_DATA;
                        data_start_o <= 1'b1;
                        data_pid_o   <= utmi_data_in_i[3:0];
                     end else if (utmi_data_in_i[1:0] == 2'b10) begin
                        r_state <= ST_HSHAKE;
                     end else begin
                        r_state <= ST_DISCARD;
                     end
                  end
               end
               default: begin
                  r_err <= r_err | (utmi_rxactive_i & utmi_rxerror_i);
                  if (w_accept) begin
                     r_cnt <= w_cnt_next;
                     if (r_state == ST_TOKEN) begin
                        r_crc5 <= w_crc5_next;
                        if (r_cnt == 11'd0) r_field[7:0]  <= utmi_data_in_i;
                        if (r_cnt == 11'd1) r_field[10:8] <= utmi_data_in_i[2:0];
                     end
                     if (r_state == ST_DATA) begin
                        r_crc16 <= w_crc16_next;
                        // Two-byte holdback: the final two bytes are the CRC.
                        case (r_hold_cnt)
                           2'd0: begin
                              r_hold0    <= utmi_data_in_i;
                              r_hold_cnt <= 2'd1;
                           end
                           2'd1: begin
                              r_hold1    <= utmi_data_in_i;
                              r_hold_cnt <= 2'd2;
                           end
                           default: begin
                              if (w_emit) begin
                                 data_valid_o <= 1'b1;
                                 data_o       <= r_hold0;
                              end
                              r_hold0 <= r_hold1;
                              r_hold1 <= utmi_data_in_i;
                           end
                        endcase
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire
